// File: rtl/accum_readout.sv
// Accumulator table with a handshaked dump engine: single-clock RAM, live entry count, sticky overflow.
// Optional ACCUM_READOUT_CLEAR_EN: zero each entry as it is accepted and reset the count when the dump ends.
module accum_readout #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 160
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           accum_addr,
    input  logic [DATA_W-1:0]     accum_din,
    input  logic                  accum_we,
    input  logic                  kick,
    output logic                  busy,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   num_entries,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

`ifdef ACCUM_READOUT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       limit_q, limit_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                done_q, done_d;
    logic [CW-1:0]       num_q, num_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data_q;

    logic                  wr_in_range;
    logic                  wr_ok;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [CW-1:0]         wr_end;
    logic [CW-1:0]         num_base;
    logic                  accept;
    logic                  last_entry;
    logic                  rd_en;

    assign wr_in_range = (accum_addr[31:DEPTH_LOG2] == '0);
    assign wr_ok       = accum_we && wr_in_range;
    assign wr_idx      = accum_addr[DEPTH_LOG2-1:0];
    assign wr_end      = {1'b0, wr_idx} + CW'(1);
    assign accept      = (state_q == S_OUT) && dout_ready;
    assign last_entry  = ((rd_ptr_q + CW'(1)) == limit_q);
    assign rd_en       = (state_q == S_FETCH);

    // NOTE: the table has no reset; contents survive reset and are only defined once written.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
`ifdef ACCUM_READOUT_CLEAR_EN
        if (accept) begin
            mem[rd_ptr_q[DEPTH_LOG2-1:0]] <= '0;
        end
`endif
        // Placed after the clear so an external write to the same address wins.
        if (wr_ok) begin
            mem[wr_idx] <= accum_din;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (kick) begin
                    limit_d  = num_q;
                    rd_ptr_d = '0;
                    state_d  = (num_q == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                dout_d  = rd_data_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (dout_ready) begin
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    state_d  = last_entry ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        num_base = (CLEAR_EN && (state_q == S_FIN)) ? '0 : num_q;
        num_d    = num_base;
        if (wr_ok && (wr_end > num_base)) begin
            num_d = wr_end;
        end
        ovf_d = ovf_q | (accum_we & ~wr_in_range);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            limit_q  <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            num_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            num_q    <= num_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign dout_valid  = (state_q == S_OUT);
    assign dout        = dout_q;
    assign done        = done_q;
    assign num_entries = num_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_accum_readout.sv
// Directed bench for accum_readout; expectations follow ACCUM_READOUT_CLEAR_EN when it is defined.
module tb_accum_readout;

    localparam int DL2 = 10;
    localparam int DW  = 160;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     accum_addr;
    logic [DW-1:0]   accum_din;
    logic            accum_we;
    logic            kick;
    logic            busy;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            done;
    logic [DL2:0]    num_entries;
    logic            overflow;

    accum_readout #(.DEPTH_LOG2(DL2), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .accum_addr  (accum_addr),
        .accum_din   (accum_din),
        .accum_we    (accum_we),
        .kick        (kick),
        .busy        (busy),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .done        (done),
        .num_entries (num_entries),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

`ifdef ACCUM_READOUT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int done_cnt, busy_cycles, first_valid_cyc, done_cyc, stall_seen;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [DW-1:0] d);
        accum_we   = 1'b1;
        accum_addr = a;
        accum_din  = d;
        step();
        accum_we   = 1'b0;
    endtask

    // Kick a dump and collect every accepted entry; cycle 1 is the first cycle after the kick edge.
    task automatic run_dump(input int stall_idx, input int stall_len, input logic [DW-1:0] stall_val,
                            input int rekick_cyc, input bit hook_en,
                            input logic [31:0] a0, input logic [DW-1:0] d0,
                            input logic [31:0] a1, input logic [DW-1:0] d1);
        int cyc;
        got_q.delete();
        done_cnt = 0; busy_cycles = 0; first_valid_cyc = -1; done_cyc = -1; stall_seen = 0;
        dout_ready = 1'b1;
        kick = 1'b1;
        step();
        cyc = 1;
        while (cyc < 200) begin
            kick = (cyc == rekick_cyc);
            accum_we = 1'b0;
            if (hook_en && cyc == 1) begin
                accum_we = 1'b1; accum_addr = a0; accum_din = d0;
            end else if (hook_en && cyc == 2) begin
                accum_we = 1'b1; accum_addr = a1; accum_din = d1;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall_seen > 0 && stall_seen < stall_len) begin
                check("stall_valid", dout_valid, 1);
                check("stall_dout", dout, stall_val);
                stall_seen++;
                dout_ready = 1'b0;
            end else if (dout_valid && got_q.size() == stall_idx && stall_seen == 0 && stall_len > 0) begin
                check("stall_dout", dout, stall_val);
                stall_seen = 1;
                dout_ready = 1'b0;
            end else begin
                dout_ready = 1'b1;
                if (dout_valid) got_q.push_back(dout);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            step();
            cyc++;
        end
        kick = 1'b0;
        accum_we = 1'b0;
        dout_ready = 1'b1;
        check("done_count", done_cnt, 1);
        check("busy_after", busy, 0);
    endtask

    task automatic check_dump(input string tag);
        check({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_e%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int late_done;
        reset = 1'b0; accum_addr = '0; accum_din = '0; accum_we = 1'b0;
        kick = 1'b0; dout_ready = 1'b1;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_done", done, 0);
        check("rst_num", num_entries, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        step();

        // Empty table: straight to FIN, busy for one cycle, done two cycles after the kick.
        run_dump(-1, 0, '0, -1, 1'b0, '0, '0, '0, '0);
        exp_q = {};
        check_dump("empty");
        check("empty_done_cyc", done_cyc, 2);
        check("empty_busy_cyc", busy_cycles, 1);
        check("empty_no_valid", first_valid_cyc, -1);

        // Three-entry dump at full rate.
        wr(0, 'hA); wr(1, 'hB); wr(2, 'hC);
        check("num3", num_entries, 3);
        run_dump(-1, 0, '0, -1, 1'b0, '0, '0, '0, '0);
        exp_q = {'hA, 'hB, 'hC};
        check_dump("basic");
        check("basic_first_valid", first_valid_cyc, 3);
        check("basic_done_cyc", done_cyc, 11);
        check("basic_busy_cyc", busy_cycles, 10);
        check("basic_num_after", num_entries, CLR ? 0 : 3);

        // Overflow write leaves the count alone; backpressure on entry 1 plus an ignored re-kick.
        wr(0, 'hA); wr(1, 'hB); wr(2, 'hC);
        wr(1024, 'hDEAD);
        check("ovf_set", overflow, 1);
        check("ovf_num", num_entries, 3);
        run_dump(1, 5, 'hB, 5, 1'b0, '0, '0, '0, '0);
        exp_q = {'hA, 'hB, 'hC};
        check_dump("stall");
        check("stall_len", stall_seen, 5);
        check("stall_done_cyc", done_cyc, 16);
        check("ovf_sticky", overflow, 1);

        // Reset in the middle of a dump.
        wr(0, 'hA); wr(1, 'hB); wr(2, 'hC);
        kick = 1'b1; step(); kick = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step();
        check("mid_busy", busy, 0);
        check("mid_valid", dout_valid, 0);
        check("mid_dout", dout, 0);
        check("mid_done", done, 0);
        check("mid_num", num_entries, 0);
        check("mid_ovf", overflow, 0);
        reset = 1'b1;
        late_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) late_done++;
        end
        check("mid_no_done", late_done, 0);
        run_dump(-1, 0, '0, -1, 1'b0, '0, '0, '0, '0);
        exp_q = {};
        check_dump("post_rst");
        check("post_rst_done_cyc", done_cyc, 2);

        // Back-to-back dumps of two entries.
        wr(0, 'h11); wr(1, 'h22);
        run_dump(-1, 0, '0, -1, 1'b0, '0, '0, '0, '0);
        exp_q = {'h11, 'h22};
        check_dump("twice_a");
        check("twice_num_a", num_entries, CLR ? 0 : 2);
        run_dump(-1, 0, '0, -1, 1'b0, '0, '0, '0, '0);
        if (CLR) exp_q = {};
        else     exp_q = {'h11, 'h22};
        check_dump("twice_b");
        check("twice_num_b", num_entries, CLR ? 0 : 2);

        // Writes during a dump: same-cycle read returns old data, entry above the limit is not dumped.
        reset = 1'b0; step(); reset = 1'b1; step();
        wr(0, 'h77);
        run_dump(-1, 0, '0, -1, 1'b1, 0, 'h99, 1, 'h88);
        exp_q = {'h77};
        check_dump("live");
        check("live_num", num_entries, CLR ? 0 : 2);
        run_dump(-1, 0, '0, -1, 1'b0, '0, '0, '0, '0);
        if (CLR) exp_q = {};
        else     exp_q = {'h99, 'h88};
        check_dump("live_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
